// File: rtl/conversor_ascii_a_tecla_if.sv
// conversor_ascii_a_tecla_if: byte-in / key-code-out handshake bundle for the ASCII-to-key converter
interface conversor_ascii_a_tecla_if #(
  parameter int PROFUNDIDAD = 4,
  parameter int ANCHO_ERR = 8
);
  logic [7:0] ascii_8bits;
  logic ascii_valid;
  logic ascii_ready;
  logic [3:0] tecla_4bits;
  logic tecla_valid;
  logic tecla_ready;
  logic error_pulso;
  logic [ANCHO_ERR-1:0] error_cuenta;
  logic [$clog2(PROFUNDIDAD):0] ocupacion;
  modport master (
    output ascii_8bits, ascii_valid, tecla_ready,
    input ascii_ready, tecla_4bits, tecla_valid, error_pulso, error_cuenta, ocupacion
  );
  modport slave (
    input ascii_8bits, ascii_valid, tecla_ready,
    output ascii_ready, tecla_4bits, tecla_valid, error_pulso, error_cuenta, ocupacion
  );
endinterface

// File: rtl/conversor_ascii_a_tecla.sv
// conversor_ascii_a_tecla: ASCII digit bytes -> 4-bit key codes through a small FIFO with error counting.
// Define DEC_ASCII_HEX_EN to also accept 'A'..'F' and 'a'..'f' as codes 4'hA..4'hF.
module conversor_ascii_a_tecla #(
  parameter int PROFUNDIDAD = 4,
  parameter int ANCHO_ERR = 8
) (
  input logic clk,
  input logic rst,
  conversor_ascii_a_tecla_if.slave bus
);
  localparam int A = $clog2(PROFUNDIDAD);
  localparam int W = A + 1;
  typedef enum logic [1:0] {VACIO, PARCIAL, LLENO} estado_t;
  estado_t estado, estado_sig;
  logic [3:0] mem [PROFUNDIDAD];
  logic [A-1:0] rd_ptr, wr_ptr;
  logic [W-1:0] cuenta, cuenta_sig;
  logic [ANCHO_ERR-1:0] errores;
  logic [3:0] codigo;
  logic listo, pulso, acepta, rechazo, push, pop, vacio, es_dig, es_hex, es_valido;
  always_comb begin
    es_dig = bus.ascii_8bits inside {[8'h30:8'h39]};
`ifdef DEC_ASCII_HEX_EN
    es_hex = bus.ascii_8bits inside {[8'h41:8'h46], [8'h61:8'h66]};
`else
    es_hex = 1'b0;
`endif
    es_valido = es_dig || es_hex;
    // letters have low nibble 1..6, so +9 lands on A..F
    codigo = es_dig ? bus.ascii_8bits[3:0] : bus.ascii_8bits[3:0] + 4'd9;
  end
  assign vacio = cuenta == '0;
  assign acepta = bus.ascii_valid && listo;
  assign rechazo = acepta && !es_valido;
  assign push = acepta && es_valido;
  assign pop = !vacio && bus.tecla_ready;
  assign cuenta_sig = cuenta + W'(push) - W'(pop);
  always_comb begin
    estado_sig = estado;
    case (estado)
      VACIO: estado_sig = push && !pop ? PARCIAL : VACIO;
      PARCIAL: estado_sig = cuenta_sig == W'(PROFUNDIDAD) ? LLENO : cuenta_sig == '0 ? VACIO : PARCIAL;
      LLENO: estado_sig = pop ? PARCIAL : LLENO;
      default: estado_sig = VACIO;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      estado <= VACIO;
      cuenta <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      listo <= 1'b0;
      pulso <= 1'b0;
      errores <= '0;
    end else begin
      estado <= estado_sig;
      cuenta <= cuenta_sig;
      listo <= estado_sig != LLENO;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      pulso <= rechazo;
      if (rechazo && errores != '1) errores <= errores + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= codigo;
  assign bus.ascii_ready = listo;
  assign bus.tecla_valid = !vacio;
  assign bus.tecla_4bits = vacio ? 4'h0 : mem[rd_ptr];
  assign bus.error_pulso = pulso;
  assign bus.error_cuenta = errores;
  assign bus.ocupacion = cuenta;
endmodule

// File: tb/tb_conversor_ascii_a_tecla.sv
// tb_conversor_ascii_a_tecla: randomized and directed stimulus against a queue-based reference model.
module tb_conversor_ascii_a_tecla;
  localparam int P = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  conversor_ascii_a_tecla_if #(.PROFUNDIDAD(P), .ANCHO_ERR(8)) bus ();
  conversor_ascii_a_tecla #(.PROFUNDIDAD(P), .ANCHO_ERR(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int pasados = 0;
  logic [3:0] q[$];
  logic m_ready = 1'b0;
  logic m_pulso = 1'b0;
  logic m_acc = 1'b0;
  int m_cuenta = 0;
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) pasados++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
  endtask
  function automatic bit decodifica(input logic [7:0] b, output logic [3:0] c);
    c = 4'h0;
    if (b >= 8'h30 && b <= 8'h39) begin c = 4'(b - 8'h30); return 1'b1; end
`ifdef DEC_ASCII_HEX_EN
    if (b >= 8'h41 && b <= 8'h46) begin c = 4'(b - 8'h37); return 1'b1; end
    if (b >= 8'h61 && b <= 8'h66) begin c = 4'(b - 8'h57); return 1'b1; end
`endif
    return 1'b0;
  endfunction
  // drive one cycle from a falling edge, advance the model at the rising edge
  task automatic paso(input logic v, input logic [7:0] b, input logic tr);
    logic [3:0] c;
    bit ok;
    bit hay_pop;
    bus.ascii_valid = v;
    bus.ascii_8bits = b;
    bus.tecla_ready = tr;
    @(posedge clk);
    ok = decodifica(b, c);
    m_acc = v && m_ready;
    hay_pop = q.size() > 0 && tr;
    if (hay_pop) void'(q.pop_front());
    if (m_acc && ok) q.push_back(c);
    m_pulso = m_acc && !ok;
    if (m_pulso && m_cuenta < 255) m_cuenta++;
    m_ready = q.size() < P;
    @(negedge clk);
  endtask
  task automatic ofrece(input logic [7:0] b, input logic tr);
    int n = 0;
    do begin paso(1'b1, b, tr); n++; end while (!m_acc && n < 50);
    chk("ofrece_acepta", int'(m_acc), 1);
  endtask
  always @(negedge clk) begin
    chk("ascii_ready", int'(bus.ascii_ready), int'(m_ready));
    chk("tecla_valid", int'(bus.tecla_valid), int'(q.size() > 0));
    if (q.size() > 0) chk("tecla_4bits", int'(bus.tecla_4bits), int'(q[0]));
    chk("ocupacion", int'(bus.ocupacion), q.size());
    chk("error_pulso", int'(bus.error_pulso), int'(m_pulso));
    chk("error_cuenta", int'(bus.error_cuenta), m_cuenta);
  end
  initial begin
    rst = 1'b0;
    bus.ascii_valid = 1'b0;
    bus.ascii_8bits = 8'h00;
    bus.tecla_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ascii_ready", int'(bus.ascii_ready), 0);
    chk("rst_tecla_valid", int'(bus.tecla_valid), 0);
    chk("rst_tecla_4bits", int'(bus.tecla_4bits), 0);
    chk("rst_ocupacion", int'(bus.ocupacion), 0);
    chk("rst_error_cuenta", int'(bus.error_cuenta), 0);
    rst = 1'b0;
    paso(1'b0, 8'h00, 1'b0);
    chk("ready_tras_rst", int'(bus.ascii_ready), 1);
    paso(1'b1, 8'h30, 1'b1);
    chk("codigo_0", int'(bus.tecla_4bits), 0);
    chk("valido_0", int'(bus.tecla_valid), 1);
    paso(1'b1, 8'h35, 1'b1);
    chk("codigo_5", int'(bus.tecla_4bits), 5);
    paso(1'b1, 8'h39, 1'b1);
    chk("codigo_9", int'(bus.tecla_4bits), 9);
    paso(1'b0, 8'h00, 1'b1);
    chk("vacio_tras_9", int'(bus.tecla_valid), 0);
    chk("sin_errores", int'(bus.error_cuenta), 0);
    for (int i = 1; i <= 4; i++) ofrece(8'(8'h30 + i), 1'b0);
    chk("lleno_ocupacion", int'(bus.ocupacion), 4);
    chk("lleno_ready", int'(bus.ascii_ready), 0);
    repeat (3) paso(1'b1, 8'h35, 1'b0);
    chk("retenido_ocupacion", int'(bus.ocupacion), 4);
    chk("retenido_sin_error", int'(bus.error_cuenta), 0);
    chk("cabeza_1", int'(bus.tecla_4bits), 1);
    ofrece(8'h35, 1'b1);
    repeat (6) paso(1'b0, 8'h00, 1'b1);
    paso(1'b1, 8'h3F, 1'b0);
    paso(1'b1, 8'h41, 1'b0);
    paso(1'b1, 8'h20, 1'b0);
`ifdef DEC_ASCII_HEX_EN
    chk("errores_3_bytes", int'(bus.error_cuenta), 2);
    chk("hex_A", int'(bus.tecla_4bits), 10);
`else
    chk("errores_3_bytes", int'(bus.error_cuenta), 3);
    chk("fifo_intacto", int'(bus.ocupacion), 0);
`endif
    for (int i = 0; i < 300; i++) paso(1'b1, 8'($urandom_range(8'h80, 8'hFF)), 1'b1);
    chk("saturacion", int'(bus.error_cuenta), 255);
    repeat (5) paso(1'b0, 8'h00, 1'b1);
    ofrece(8'h32, 1'b0);
    ofrece(8'h37, 1'b0);
    for (int i = 0; i < 20; i++) begin
      paso(1'b1, 8'(8'h30 + $urandom_range(0, 9)), 1'b1);
      chk("estable_2", int'(bus.ocupacion), 2);
    end
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] b;
      b = $urandom_range(0, 3) != 0 ? 8'(8'h30 + $urandom_range(0, 9)) : 8'($urandom_range(0, 255));
      paso(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 2) == 0));
    end
    repeat (6) paso(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) ofrece(8'(8'h31 + i), 1'b0);
    chk("pre_rst_ocupacion", int'(bus.ocupacion), 3);
    #2 rst = 1'b1;
    q.delete();
    m_ready = 1'b0;
    m_pulso = 1'b0;
    m_cuenta = 0;
    #1;
    chk("rst_async_valid", int'(bus.tecla_valid), 0);
    chk("rst_async_ocupacion", int'(bus.ocupacion), 0);
    chk("rst_async_cuenta", int'(bus.error_cuenta), 0);
    chk("rst_async_ready", int'(bus.ascii_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    paso(1'b0, 8'h00, 1'b0);
    ofrece(8'h37, 1'b0);
    chk("post_rst_codigo", int'(bus.tecla_4bits), 7);
    chk("post_rst_ocupacion", int'(bus.ocupacion), 1);
    $display("%0d/%0d checks passed", pasados, total);
    $finish;
  end
endmodule
